trigger_timestamp: RTL and testbench

- Timestamps rising edges of an external trigger (LEMO_RX) against a free-running 48-bit counter.
- Buffers the timestamps and presents them as 32-bit words on the standard FIFO_READ/FIFO_EMPTY/FIFO_DATA source interface.
- Plugs into the unused third request slot of the round-robin arbiter that feeds the SRAM FIFO, so trigger times are interleaved with pixel and TDC data in one stream.

---
 rtl/trigger_timestamp.sv | 193 +++++++++++++++++++
 tb/tb_trigger_timestamp.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_timestamp.sv
// -----------------------------------------------------------------------------
// trigger_timestamp
//
// Timestamps rising edges of an asynchronous trigger against a free-running
// 48-bit counter. The timestamps are buffered and presented as pairs of 32-bit
// words on a first-word fall-through FIFO source interface. This lets the
// block sit in a round-robin arbiter slot next to other data sources.
//
// Ports
//   BUS_CLK     in   1   single clock for all logic
//   BUS_RST     in   1   synchronous reset, active-high
//   EN          in   1   capture enable; trigger edges are ignored while low
//   RESET_TS    in   1   synchronous clear of the timestamp counter
//   TRIG_IN     in   1   asynchronous trigger input
//   FIFO_READ   in   1   pop strobe from the arbiter
//   FIFO_EMPTY  out  1   high when no word is available
//   FIFO_DATA   out  32  current word, valid while FIFO_EMPTY is low, else 0
//   TIMESTAMP   out  48  current counter value
//   LOST_CNT    out  8   triggers dropped on a full buffer (saturating)
//
// Word format, two words per event:
//   high word: {DATA_IDENTIFIER, 4'b0001, ts[47:24]}
//   low word:  {DATA_IDENTIFIER, 4'b0010, ts[23:0]}
// -----------------------------------------------------------------------------
module trigger_timestamp #(
    parameter logic [3:0] DATA_IDENTIFIER = 4'b0110,
    parameter int          DEPTH           = 8      // power of two, >= 2
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        EN,
    input  logic        RESET_TS,
    input  logic        TRIG_IN,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [47:0] TIMESTAMP,
    output logic [7:0]  LOST_CNT
);

    localparam int              AW         = $clog2(DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    // Which half of the head entry is currently on FIFO_DATA.
    typedef enum logic {
        PH_HIGH = 1'b0,
        PH_LOW  = 1'b1
    } phase_t;

    // -------------------------------------------------------------------------
    // Free-running timestamp counter
    // -------------------------------------------------------------------------
    logic [47:0] ts_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || RESET_TS) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 48'd1;   // wraps naturally at 2^48
        end
    end

    assign TIMESTAMP = ts_cnt;

    // -------------------------------------------------------------------------
    // Trigger synchroniser and rising-edge detection
    // s1/s2 resolve metastability; s3 and prev give a clean edge compare, so a
    // level held high yields a single event.
    // -------------------------------------------------------------------------
    logic trig_s1, trig_s2, trig_s3, trig_prev;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_s3   <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_s1   <= TRIG_IN;
            trig_s2   <= trig_s1;
            trig_s3   <= trig_s2;
            trig_prev <= trig_s3;
        end
    end

    logic trig_edge;
    assign trig_edge = trig_s3 & ~trig_prev;

    // -------------------------------------------------------------------------
    // Event buffer control
    // -------------------------------------------------------------------------
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    phase_t        phase, phase_next;

    logic buf_empty, buf_full;
    logic capture, do_write, do_drop;
    logic rd_ok, do_pop;

    assign buf_empty = (count == '0);
    // Fullness comes from the registered count, so a pop on the same edge
    // does not make room for the incoming event.
    assign buf_full  = (count == FULL_COUNT);

    assign capture   = trig_edge & EN;
    assign do_write  = capture & ~buf_full;
    assign do_drop   = capture &  buf_full;

    // A read strobe on an empty buffer has no effect at all.
    assign rd_ok     = FIFO_READ & ~buf_empty;
    assign do_pop    = rd_ok & (phase == PH_LOW);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        phase_next = phase;
        if (rd_ok) begin
            phase_next = (phase == PH_HIGH) ? PH_LOW : PH_HIGH;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            phase  <= PH_HIGH;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            phase <= phase_next;
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;   // idle, or write and pop together
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [47:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and the output is forced to 0 when empty.
    always_ff @(posedge BUS_CLK) begin
        if (do_write && !BUS_RST) begin
            mem[wr_ptr] <= ts_cnt;
        end
    end

    // -------------------------------------------------------------------------
    // Lost-event counter, saturating
    // -------------------------------------------------------------------------
    logic [7:0] lost_cnt;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            lost_cnt <= '0;
        end else if (do_drop && (lost_cnt != 8'hFF)) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end

    assign LOST_CNT = lost_cnt;

    // -------------------------------------------------------------------------
    // Output word decode
    // -------------------------------------------------------------------------
    logic [47:0] head;
    assign head       = mem[rd_ptr];
    assign FIFO_EMPTY = buf_empty;

    always_comb begin
        FIFO_DATA = '0;
        if (!buf_empty) begin
            if (phase == PH_HIGH) begin
                FIFO_DATA = {DATA_IDENTIFIER, 4'b0001, head[47:24]};
            end else begin
                FIFO_DATA = {DATA_IDENTIFIER, 4'b0010, head[23:0]};
            end
        end
    end

endmodule

// File: tb/tb_trigger_timestamp.sv
// -----------------------------------------------------------------------------
// tb_trigger_timestamp
//
// Directed bench for trigger_timestamp. A behavioural model (queue of captured
// timestamps, read phase, counter and lost count) predicts the outputs; a
// compare process checks them on every falling edge. Directed sequences add
// hand-computed word values at the key points.
// -----------------------------------------------------------------------------
module tb_trigger_timestamp;

    localparam logic [3:0] ID    = 4'b0110;
    localparam int         DEPTH = 8;

    logic        BUS_CLK;
    logic        BUS_RST;
    logic        EN;
    logic        RESET_TS;
    logic        TRIG_IN;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [47:0] TIMESTAMP;
    logic [7:0]  LOST_CNT;

    trigger_timestamp #(
        .DATA_IDENTIFIER (ID),
        .DEPTH           (DEPTH)
    ) dut (
        .BUS_CLK    (BUS_CLK),
        .BUS_RST    (BUS_RST),
        .EN         (EN),
        .RESET_TS   (RESET_TS),
        .TRIG_IN    (TRIG_IN),
        .FIFO_READ  (FIFO_READ),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DATA  (FIFO_DATA),
        .TIMESTAMP  (TIMESTAMP),
        .LOST_CNT   (LOST_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [47:0] m_q[$];       // captured timestamps, oldest first
    bit          m_low;        // 1 once the high word of the head was read
    logic [47:0] m_ts;
    logic [7:0]  m_lost;
    bit [3:0]    m_trig_ago;   // TRIG_IN as seen 1,2,3,4 edges ago (bit 0 = 1 ago)
    bit          m_hold;       // counter held by a bench force
    bit          m_live = 1'b0;
    bit          m_event, m_was_full;

    always @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            m_q.delete();
            m_low      = 1'b0;
            m_ts       = '0;
            m_lost     = '0;
            m_trig_ago = '0;
            m_live     = 1'b1;
        end else begin
            // A rising edge of TRIG_IN seen three edges ago is captured now.
            m_event    = m_trig_ago[2] && !m_trig_ago[3] && EN;
            m_was_full = (m_q.size() == DEPTH);
            if (FIFO_READ && m_q.size() != 0) begin
                if (m_low) void'(m_q.pop_front());
                m_low = !m_low;
            end
            if (m_event) begin
                if (m_was_full) begin
                    if (m_lost != 8'hFF) m_lost = m_lost + 8'd1;
                end else begin
                    m_q.push_back(m_ts);
                end
            end
            m_trig_ago = {m_trig_ago[2:0], TRIG_IN};
            if (RESET_TS)     m_ts = '0;
            else if (!m_hold) m_ts = m_ts + 48'd1;
        end
    end

    logic [31:0] m_data;
    always @(negedge BUS_CLK) begin
        if (m_live) begin
            m_data = '0;
            if (m_q.size() != 0) begin
                m_data = m_low ? {ID, 4'b0010, m_q[0][23:0]} : {ID, 4'b0001, m_q[0][47:24]};
            end
            check("model FIFO_EMPTY", 64'(FIFO_EMPTY), 64'(m_q.size() == 0));
            check("model FIFO_DATA",  64'(FIFO_DATA),  64'(m_data));
            check("model TIMESTAMP",  64'(TIMESTAMP),  64'(m_ts));
            check("model LOST_CNT",   64'(LOST_CNT),   64'(m_lost));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(negedge BUS_CLK);
        #1;
    endtask

    task automatic read_word(input string name, input logic [31:0] exp);
        int waited = 0;
        while (FIFO_EMPTY && waited < 40) begin
            cyc();
            waited++;
        end
        check({name, " available"}, 64'(FIFO_EMPTY), 64'd0);
        check(name, 64'(FIFO_DATA), 64'(exp));
        FIFO_READ = 1'b1;
        cyc();
        FIFO_READ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Directed sequences
    // -------------------------------------------------------------------------
    initial begin
        BUS_RST   = 1'b1;
        EN        = 1'b0;
        RESET_TS  = 1'b0;
        TRIG_IN   = 1'b0;
        FIFO_READ = 1'b0;
        m_hold    = 1'b0;
        repeat (3) cyc();

        // Reset values
        check("reset FIFO_EMPTY", 64'(FIFO_EMPTY), 64'd1);
        check("reset FIFO_DATA",  64'(FIFO_DATA),  64'd0);
        check("reset TIMESTAMP",  64'(TIMESTAMP),  64'd0);
        check("reset LOST_CNT",   64'(LOST_CNT),   64'd0);
        BUS_RST = 1'b0;
        EN      = 1'b1;
        repeat (3) cyc();

        // --- single 4-cycle pulse, capture value 0x123456 ---
        force dut.ts_cnt = 48'h0000_0012_3454;
        m_ts = 48'h0000_0012_3454; m_hold = 1'b1;
        TRIG_IN = 1'b1;                               // sampled at edge k
        cyc();
        release dut.ts_cnt;
        m_hold = 1'b0;
        cyc();
        cyc();                                        // state after edge k+2
        check("t1 empty before write", 64'(FIFO_EMPTY), 64'd1);
        check("t1 timestamp in edge cycle", 64'(TIMESTAMP), 64'h0000_0012_3456);
        cyc();                                        // state after edge k+3
        TRIG_IN = 1'b0;
        check("t1 empty after write", 64'(FIFO_EMPTY), 64'd0);
        read_word("t1 high word", 32'h6100_0000);
        read_word("t1 low word",  32'h6212_3456);
        check("t1 empty after drain", 64'(FIFO_EMPTY), 64'd1);
        repeat (4) cyc();

        // --- counter wrap: captures at 0xFFFFFFFFFFFF and 0x000000000005 ---
        force dut.ts_cnt = 48'hFFFF_FFFF_FFFD;
        m_ts = 48'hFFFF_FFFF_FFFD; m_hold = 1'b1;
        TRIG_IN = 1'b1;                               // edge k
        cyc();
        release dut.ts_cnt;
        m_hold  = 1'b0;
        TRIG_IN = 1'b0;
        cyc();
        cyc();                                        // after edge k+2
        check("t2 timestamp max", 64'(TIMESTAMP), 64'hFFFF_FFFF_FFFF);
        cyc();                                        // after edge k+3
        check("t2 timestamp wrapped", 64'(TIMESTAMP), 64'd0);
        cyc();
        cyc();
        TRIG_IN = 1'b1;                               // edge k+6
        cyc();
        TRIG_IN = 1'b0;
        read_word("t2 wrap high", 32'h61FF_FFFF);
        read_word("t2 wrap low",  32'h62FF_FFFF);
        read_word("t2 next high", 32'h6100_0000);
        read_word("t2 next low",  32'h6200_0005);
        repeat (4) cyc();

        // --- overflow: 10 triggers 8 cycles apart, no reads ---
        RESET_TS = 1'b1;                              // edge r
        cyc();
        RESET_TS = 1'b0;
        check("t3 RESET_TS clears", 64'(TIMESTAMP), 64'd0);
        for (int i = 0; i < 10; i++) begin            // trigger i at edge r+1+8i
            TRIG_IN = 1'b1;
            repeat (4) cyc();
            TRIG_IN = 1'b0;
            repeat (4) cyc();
        end
        check("t3 lost count", 64'(LOST_CNT), 64'd2);
        for (int i = 0; i < DEPTH; i++) begin
            read_word("t3 high", 32'h6100_0000);
            read_word("t3 low",  {8'h62, 24'(3 + 8 * i)});
        end
        check("t3 empty after 16 words", 64'(FIFO_EMPTY), 64'd1);
        repeat (4) cyc();

        // --- simultaneous pop and capture on one edge ---
        RESET_TS = 1'b1;                              // edge r
        cyc();
        RESET_TS = 1'b0;
        TRIG_IN  = 1'b1;                              // A sampled at r+1
        cyc();
        TRIG_IN = 1'b0;
        cyc();
        cyc();
        cyc();                                        // A written at r+4
        check("t4 A high", 64'(FIFO_DATA), 64'h6100_0000);
        FIFO_READ = 1'b1;                             // high-word read at r+5
        cyc();
        FIFO_READ = 1'b0;
        TRIG_IN   = 1'b1;                             // B sampled at r+6
        check("t4 A low", 64'(FIFO_DATA), 64'h6200_0003);
        cyc();
        TRIG_IN = 1'b0;
        cyc();
        cyc();
        FIFO_READ = 1'b1;                             // pop A and write B at r+9
        cyc();
        FIFO_READ = 1'b0;
        check("t4 still one entry", 64'(FIFO_EMPTY), 64'd0);
        read_word("t4 B high", 32'h6100_0000);
        read_word("t4 B low",  32'h6200_0008);
        check("t4 empty after B", 64'(FIFO_EMPTY), 64'd1);
        repeat (4) cyc();

        // --- EN=0 drops silently ---
        EN      = 1'b0;
        TRIG_IN = 1'b1;
        repeat (2) cyc();
        TRIG_IN = 1'b0;
        repeat (6) cyc();
        check("t5 EN=0 no entry", 64'(FIFO_EMPTY), 64'd1);
        check("t5 EN=0 lost unchanged", 64'(LOST_CNT), 64'd2);
        EN = 1'b1;

        // --- level held high for 100 cycles gives one event ---
        RESET_TS = 1'b1;
        cyc();
        RESET_TS = 1'b0;
        TRIG_IN  = 1'b1;
        repeat (100) cyc();
        TRIG_IN = 1'b0;
        repeat (5) cyc();
        read_word("t5 level high", 32'h6100_0000);
        read_word("t5 level low",  32'h6200_0003);
        check("t5 single entry", 64'(FIFO_EMPTY), 64'd1);
        repeat (4) cyc();

        // --- reset mid-read with 3 entries buffered ---
        RESET_TS = 1'b1;
        cyc();
        RESET_TS = 1'b0;
        repeat (3) begin
            TRIG_IN = 1'b1;
            repeat (2) cyc();
            TRIG_IN = 1'b0;
            repeat (2) cyc();
        end
        repeat (4) cyc();
        read_word("t6 first high", 32'h6100_0000);    // now in phase 1
        BUS_RST = 1'b1;                               // edge R
        cyc();
        BUS_RST = 1'b0;
        check("t6 reset empty",     64'(FIFO_EMPTY), 64'd1);
        check("t6 reset data",      64'(FIFO_DATA),  64'd0);
        check("t6 reset timestamp", 64'(TIMESTAMP),  64'd0);
        check("t6 reset lost",      64'(LOST_CNT),   64'd0);
        TRIG_IN = 1'b1;                               // edge R+1
        cyc();
        TRIG_IN = 1'b0;
        read_word("t6 restart high", 32'h6100_0000);
        read_word("t6 restart low",  32'h6200_0003);
        check("t6 empty at end", 64'(FIFO_EMPTY), 64'd1);
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
